cluster_pwr_iso_seq: RTL

//  Parametrised power-domain sequencer with integrated output isolation for a switchable cluster.

---
 rtl/cluster_pwr_iso_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cluster_pwr_iso_seq.sv
// Power-domain sequencer for a switchable cluster: orders switch enable, domain reset and
// isolation clamp, and clamps the outgoing data bus while the domain is isolated.
module cluster_pwr_iso_seq #(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  CLAMP_VAL   = '0,
    parameter int unsigned       ISO_CYC     = 4,
    parameter int unsigned       RST_CYC     = 8,
    parameter int unsigned       ACK_TIMEOUT = 255,
    parameter bit                BOOT_ON     = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pwr_down_req_i,
    input  logic             pwr_up_req_i,
    output logic             pwr_sw_en_o,
    input  logic             pwr_sw_ack_i,
    output logic             rst_dom_o,
    output logic             iso_o,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             on_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned MAX_DWELL = (ISO_CYC > RST_CYC) ? ISO_CYC : RST_CYC;
    localparam int unsigned MAX_CYC   = (MAX_DWELL > ACK_TIMEOUT) ? MAX_DWELL : ACK_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_SW_ON    = 3'd1,
        ST_RST_HOLD = 3'd2,
        ST_REL_ISO  = 3'd3,
        ST_ON       = 3'd4,
        ST_ISO_SET  = 3'd5,
        ST_SW_OFF   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             boot_q, boot_d;
    logic             sw_en_q, sw_en_d;
    logic             rst_dom_q, rst_dom_d;
    logic             iso_q, iso_d;
    logic             on_q, on_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             cnt_zero;

    // Counter preload so that a state is occupied for exactly N cycles (expires at 0).
    function automatic logic [CNT_W-1:0] load_val(input state_e s);
        logic [CNT_W-1:0] v;
        v = '0;
        case (s)
            ST_SW_ON, ST_SW_OFF:    v = ACK_LD;
            ST_RST_HOLD:            v = RST_LD;
            ST_REL_ISO, ST_ISO_SET: v = ISO_LD;
            default:                v = '0;
        endcase
        return v;
    endfunction

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        boot_d  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (boot_q || pwr_up_req_i) begin
                    state_d = ST_SW_ON;
                    err_d   = 1'b0;
                end
            end
            ST_SW_ON: begin
                // An ack landing on the expiry cycle takes priority over the error.
                if (pwr_sw_ack_i) begin
                    state_d = ST_RST_HOLD;
                end else if (cnt_zero) begin
                    err_d = 1'b1;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_REL_ISO;
                end
            end
            ST_REL_ISO: begin
                if (cnt_zero) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (pwr_down_req_i) begin
                    state_d = ST_ISO_SET;
                    err_d   = 1'b0;
                end
            end
            ST_ISO_SET: begin
                if (cnt_zero) begin
                    state_d = ST_SW_OFF;
                end
            end
            ST_SW_OFF: begin
                if (!pwr_sw_ack_i) begin
                    state_d = ST_OFF;
                end else if (cnt_zero) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = load_val(state_d);
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        sw_en_d   = 1'b1;
        rst_dom_d = 1'b1;
        iso_d     = 1'b1;
        case (state_d)
            ST_OFF, ST_SW_OFF: sw_en_d = 1'b0;
            ST_REL_ISO:        rst_dom_d = 1'b0;
            ST_ON: begin
                rst_dom_d = 1'b0;
                iso_d     = 1'b0;
            end
            default: begin
                sw_en_d   = 1'b1;
                rst_dom_d = 1'b1;
                iso_d     = 1'b1;
            end
        endcase
        on_d   = (state_d == ST_ON);
        busy_d = (state_d != ST_ON) && (state_d != ST_OFF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            boot_q    <= BOOT_ON;
            sw_en_q   <= 1'b0;
            rst_dom_q <= 1'b1;
            iso_q     <= 1'b1;
            on_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            boot_q    <= boot_d;
            sw_en_q   <= sw_en_d;
            rst_dom_q <= rst_dom_d;
            iso_q     <= iso_d;
            on_q      <= on_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign pwr_sw_en_o = sw_en_q;
    assign rst_dom_o   = rst_dom_q;
    assign iso_o       = iso_q;
    assign on_o        = on_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign data_o      = iso_q ? CLAMP_VAL : data_i;

endmodule
